// File: rtl/exe_stage_if.sv
// EXE stage bus: decoded instruction fields in, MEM-stage bundle out.
// Branch outputs are combinational; the rest of the outputs are registered.
interface exe_stage_if;
  logic        freeze;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        b_in;
  logic        s_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] val_rn_in;
  logic [31:0] val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;
  logic [31:0] pc_in;
  logic [3:0]  sr_in;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] mem_fwd_val;
  logic [31:0] wb_fwd_val;

  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic [3:0]  dest;

  modport master (
    output freeze,
    output wb_en_in,
    output mem_r_en_in,
    output mem_w_en_in,
    output b_in,
    output s_in,
    output exe_cmd_in,
    output val_rn_in,
    output val_rm_in,
    output imm_in,
    output shift_operand_in,
    output signed_imm_24_in,
    output dest_in,
    output pc_in,
    output sr_in,
    output sel_src1,
    output sel_src2,
    output mem_fwd_val,
    output wb_fwd_val,
    input  branch_taken,
    input  branch_addr,
    input  status,
    input  wb_en,
    input  mem_r_en,
    input  mem_w_en,
    input  alu_res,
    input  st_val,
    input  dest
  );

  modport slave (
    input  freeze,
    input  wb_en_in,
    input  mem_r_en_in,
    input  mem_w_en_in,
    input  b_in,
    input  s_in,
    input  exe_cmd_in,
    input  val_rn_in,
    input  val_rm_in,
    input  imm_in,
    input  shift_operand_in,
    input  signed_imm_24_in,
    input  dest_in,
    input  pc_in,
    input  sr_in,
    input  sel_src1,
    input  sel_src2,
    input  mem_fwd_val,
    input  wb_fwd_val,
    output branch_taken,
    output branch_addr,
    output status,
    output wb_en,
    output mem_r_en,
    output mem_w_en,
    output alu_res,
    output st_val,
    output dest
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, operand-2 shifter, ALU, flags,
// branch target and the EXE/MEM pipeline register.
module exe_stage (
  input  logic       clk,
  input  logic       rst,
  exe_stage_if.slave bus
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  logic [31:0] op1;
  logic [31:0] fwd_rm;
  logic [31:0] val2;
  logic [31:0] imm8;
  logic [4:0]  rot;
  logic [4:0]  sh_amt;
  logic [1:0]  sh_typ;
  logic [31:0] sh_res;
  logic [32:0] sum;
  logic [31:0] res;
  logic        c_in;
  logic        c_out;
  logic        v_out;
  logic        is_add;
  logic        is_sub;
  logic [3:0]  flags;

  always_comb begin
    op1 = bus.val_rn_in;
    unique case (1'b1)
      bus.sel_src1 == 2'b01: op1 = bus.mem_fwd_val;
      bus.sel_src1 == 2'b10: op1 = bus.wb_fwd_val;
      default:               op1 = bus.val_rn_in;
    endcase
  end

  always_comb begin
    fwd_rm = bus.val_rm_in;
    unique case (1'b1)
      bus.sel_src2 == 2'b01: fwd_rm = bus.mem_fwd_val;
      bus.sel_src2 == 2'b10: fwd_rm = bus.wb_fwd_val;
      default:               fwd_rm = bus.val_rm_in;
    endcase
  end

  assign imm8   = {24'b0, bus.shift_operand_in[7:0]};
  assign rot    = {bus.shift_operand_in[11:8], 1'b0};
  assign sh_amt = bus.shift_operand_in[11:7];
  assign sh_typ = bus.shift_operand_in[6:5];

  always_comb begin
    sh_res = fwd_rm;
    if (sh_amt != 5'd0) begin
      unique case (sh_typ)
        2'b00: sh_res = fwd_rm << sh_amt;
        2'b01: sh_res = fwd_rm >> sh_amt;
        2'b10: sh_res = $signed(fwd_rm) >>> sh_amt;
        default:
          sh_res = (fwd_rm >> sh_amt)
                 | (fwd_rm << (6'd32 - {1'b0, sh_amt}));
      endcase
    end
  end

  // Memory ops use the raw 12-bit offset, ignoring shifter encoding.
  always_comb begin
    val2 = sh_res;
    if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      val2 = {20'b0, bus.shift_operand_in};
    end else if (bus.imm_in) begin
      val2 = (rot == 5'd0) ? imm8
           : (imm8 >> rot) | (imm8 << (6'd32 - {1'b0, rot}));
    end
  end

  assign c_in = bus.sr_in[1];

  always_comb begin
    sum    = 33'd0;
    res    = 32'd0;
    is_add = 1'b0;
    is_sub = 1'b0;
    unique case (bus.exe_cmd_in)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD: begin
        sum    = {1'b0, op1} + {1'b0, val2};
        res    = sum[31:0];
        is_add = 1'b1;
      end
      CMD_ADC: begin
        sum    = {1'b0, op1} + {1'b0, val2} + {32'b0, c_in};
        res    = sum[31:0];
        is_add = 1'b1;
      end
      CMD_SUB: begin
        sum    = {1'b0, op1} + {1'b0, ~val2} + 33'd1;
        res    = sum[31:0];
        is_sub = 1'b1;
      end
      CMD_SBC: begin
        sum    = {1'b0, op1} + {1'b0, ~val2} + {32'b0, c_in};
        res    = sum[31:0];
        is_sub = 1'b1;
      end
      CMD_AND: res = op1 & val2;
      CMD_ORR: res = op1 | val2;
      CMD_EOR: res = op1 ^ val2;
      default: res = 32'd0;
    endcase
  end

  // Subtraction runs as op1 + ~val2 + cin, so carry-out is no-borrow.
  always_comb begin
    c_out = bus.sr_in[1];
    v_out = bus.sr_in[0];
    if (is_add) begin
      c_out = sum[32];
      v_out = (op1[31] == val2[31]) && (res[31] != op1[31]);
    end else if (is_sub) begin
      c_out = sum[32];
      v_out = (op1[31] != val2[31]) && (res[31] != op1[31]);
    end
  end

  assign flags = {res[31], res == 32'd0, c_out, v_out};

  assign bus.branch_taken = bus.b_in;
  assign bus.branch_addr  = bus.pc_in
    + {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_en    <= 1'b0;
      bus.mem_r_en <= 1'b0;
      bus.mem_w_en <= 1'b0;
      bus.dest     <= 4'b1111;
      bus.alu_res  <= 32'd0;
      bus.st_val   <= 32'd0;
    end else if (!bus.freeze) begin
      bus.wb_en    <= bus.wb_en_in;
      bus.mem_r_en <= bus.mem_r_en_in;
      bus.mem_w_en <= bus.mem_w_en_in;
      bus.dest     <= bus.dest_in;
      bus.alu_res  <= res;
      bus.st_val   <= fwd_rm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.status <= 4'b0000;
    end else if (bus.s_in && !bus.freeze) begin
      bus.status <= flags;
    end
  end

endmodule
